// File: rtl/id_exe_issue.sv
// ARM-style decode/issue stage: builds the EXE_CMD control word, evaluates the
// condition field against forwarded NZCV and registers the result into ID/EX.
module id_exe_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] instr,
   input  logic        stall,
   input  logic        flush,
   input  logic        flag_we,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_c,
   input  logic        alu_v,
   output logic        ex_valid,
   output logic [3:0]  ex_cmd,
   output logic        ex_mem_r,
   output logic        ex_mem_w,
   output logic        ex_wb_en,
   output logic        ex_s,
   output logic        ex_b,
   output logic        ex_imm,
   output logic [3:0]  ex_rn,
   output logic [3:0]  ex_rm,
   output logic [3:0]  ex_rd,
   output logic [11:0] ex_shift_op,
   output logic [23:0] ex_imm24,
   output logic [3:0]  status,
   output logic        illegal
);

   typedef struct packed {
      logic        valid;
      logic [3:0]  cmd;
      logic        mem_r;
      logic        mem_w;
      logic        wb_en;
      logic        s;
      logic        b;
      logic        imm;
      logic [3:0]  rn;
      logic [3:0]  rm;
      logic [3:0]  rd;
      logic [11:0] shift_op;
      logic [23:0] imm24;
   } id_ex_t;

   localparam id_ex_t BUBBLE = '0;

   id_ex_t     dec;
   id_ex_t     id_ex_q;
   logic       legal;
   logic       pass;
   logic [3:0] f;
   logic       fn, fz, fc, fv;

   always_comb begin
      dec          = '0;
      legal        = 1'b0;
      dec.valid    = 1'b1;
      dec.rn       = instr[19:16];
      dec.rd       = instr[15:12];
      dec.rm       = instr[3:0];
      dec.shift_op = instr[11:0];
      dec.imm24    = instr[23:0];
      case (instr[27:26])
         2'b00: begin
            legal     = 1'b1;
            dec.imm   = instr[25];
            dec.wb_en = 1'b1;
            dec.s     = instr[20];
            case (instr[24:21])
               4'b0000: dec.cmd = 4'b0110;
               4'b0001: dec.cmd = 4'b1000;
               4'b0010: dec.cmd = 4'b0100;
               4'b0100: dec.cmd = 4'b0010;
               4'b0101: dec.cmd = 4'b0011;
               4'b0110: dec.cmd = 4'b0101;
               4'b1000: begin
                  dec.cmd   = 4'b0110;
                  dec.wb_en = 1'b0;
                  dec.s     = 1'b1;
               end
               4'b1010: begin
                  dec.cmd   = 4'b0100;
                  dec.wb_en = 1'b0;
                  dec.s     = 1'b1;
               end
               4'b1100: dec.cmd = 4'b0111;
               4'b1101: dec.cmd = 4'b0001;
               4'b1111: dec.cmd = 4'b1001;
               default: legal = 1'b0;
            endcase
         end
         2'b01: begin
            legal     = 1'b1;
            dec.cmd   = 4'b0010;
            dec.imm   = ~instr[25];
            dec.mem_r = instr[20];
            dec.wb_en = instr[20];
            dec.mem_w = ~instr[20];
         end
         2'b10: begin
            legal = 1'b1;
            dec.b = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // Forward the flags of an S-instruction currently in EX.
   assign f = flag_we ? {alu_n, alu_z, alu_c, alu_v} : status;
   assign {fn, fz, fc, fv} = f;

   always_comb begin
      case (instr[31:28])
         4'b0000: pass = fz;
         4'b0001: pass = ~fz;
         4'b0010: pass = fc;
         4'b0011: pass = ~fc;
         4'b0100: pass = fn;
         4'b0101: pass = ~fn;
         4'b0110: pass = fv;
         4'b0111: pass = ~fv;
         4'b1000: pass = fc & ~fz;
         4'b1001: pass = ~fc | fz;
         4'b1010: pass = (fn == fv);
         4'b1011: pass = (fn != fv);
         4'b1100: pass = ~fz & (fn == fv);
         4'b1101: pass = fz | (fn != fv);
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_ex_q <= BUBBLE;
         illegal <= 1'b0;
      end else if (flush) begin
         id_ex_q <= BUBBLE;
         illegal <= 1'b0;
      end else if (!stall) begin
         if (in_valid && legal && pass) begin
            id_ex_q <= dec;
            illegal <= 1'b0;
         end else begin
            id_ex_q <= BUBBLE;
            illegal <= in_valid & ~legal;
         end
      end
   end

   // NZCV belongs to the instruction already in EX, so stall/flush don't gate it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status <= 4'b0000;
      end else if (flag_we) begin
         status <= {alu_n, alu_z, alu_c, alu_v};
      end
   end

   assign ex_valid    = id_ex_q.valid;
   assign ex_cmd      = id_ex_q.cmd;
   assign ex_mem_r    = id_ex_q.mem_r;
   assign ex_mem_w    = id_ex_q.mem_w;
   assign ex_wb_en    = id_ex_q.wb_en;
   assign ex_s        = id_ex_q.s;
   assign ex_b        = id_ex_q.b;
   assign ex_imm      = id_ex_q.imm;
   assign ex_rn       = id_ex_q.rn;
   assign ex_rm       = id_ex_q.rm;
   assign ex_rd       = id_ex_q.rd;
   assign ex_shift_op = id_ex_q.shift_op;
   assign ex_imm24    = id_ex_q.imm24;

endmodule

// File: tb/tb_id_exe_issue.sv
// Scoreboard bench for id_exe_issue: directed vectors push expected output
// words; a posedge monitor pops and compares them.
module tb_id_exe_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] instr;
   logic        stall;
   logic        flush;
   logic        flag_we;
   logic        alu_n, alu_z, alu_c, alu_v;
   logic        ex_valid;
   logic [3:0]  ex_cmd;
   logic        ex_mem_r, ex_mem_w, ex_wb_en, ex_s, ex_b, ex_imm;
   logic [3:0]  ex_rn, ex_rm, ex_rd;
   logic [11:0] ex_shift_op;
   logic [23:0] ex_imm24;
   logic [3:0]  status;
   logic        illegal;

   typedef struct {
      logic [63:0] v;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;
   logic [63:0] act;

   always #5 clk = ~clk;

   id_exe_issue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
      .stall(stall), .flush(flush), .flag_we(flag_we),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .ex_valid(ex_valid), .ex_cmd(ex_cmd),
      .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_wb_en(ex_wb_en),
      .ex_s(ex_s), .ex_b(ex_b), .ex_imm(ex_imm),
      .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
      .ex_shift_op(ex_shift_op), .ex_imm24(ex_imm24),
      .status(status), .illegal(illegal)
   );

   assign act = {ex_valid, ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_s,
                 ex_b, ex_imm, ex_rn, ex_rm, ex_rd, ex_shift_op,
                 ex_imm24, status, illegal};

   // ctl = {mem_r, mem_w, wb_en, s, b, imm}
   function automatic logic [63:0] ev(
      input logic v, input logic [3:0] cmd, input logic [5:0] ctl,
      input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
      input logic [11:0] sh, input logic [23:0] i24,
      input logic [3:0] st, input logic ill);
      return {v, cmd, ctl, rn, rm, rd, sh, i24, st, ill};
   endfunction

   function automatic logic [63:0] bub(input logic [3:0] st,
                                       input logic ill);
      return {59'd0, st, ill};
   endfunction

   always @(posedge clk) begin
      if (mon_en) begin
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (act !== e.v) begin
               fails++;
               $display("FAIL %s: got %h expected %h", e.name, act, e.v);
            end
         end
      end
   end

   task automatic drive(input string name, input logic [31:0] ins,
                        input logic vld, input logic stl, input logic fls,
                        input logic fwe, input logic [3:0] fl,
                        input logic [63:0] e);
      exp_t x;
      @(negedge clk);
      instr    = ins;
      in_valid = vld;
      stall    = stl;
      flush    = fls;
      flag_we  = fwe;
      {alu_n, alu_z, alu_c, alu_v} = fl;
      x.v    = e;
      x.name = name;
      exp_q.push_back(x);
   endtask

   task automatic drain;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   localparam logic [63:0] E_ADD0 =
      {1'b1, 4'b0010, 6'b001000, 4'd2, 4'd3, 4'd1, 12'h003,
       24'h821003, 4'b0000, 1'b0};
   localparam logic [63:0] E_ADD4 =
      {1'b1, 4'b0010, 6'b001000, 4'd2, 4'd3, 4'd1, 12'h003,
       24'h821003, 4'b0100, 1'b0};
   localparam logic [63:0] E_ADD9 =
      {1'b1, 4'b0010, 6'b001000, 4'd2, 4'd3, 4'd1, 12'h003,
       24'h821003, 4'b1001, 1'b0};

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      instr    = 32'h0;
      stall    = 1'b0;
      flush    = 1'b0;
      flag_we  = 1'b0;
      {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
      repeat (2) @(posedge clk);
      #2;
      tests++;
      if (act !== 64'd0) begin
         fails++;
         $display("FAIL reset: got %h expected %h", act, 64'd0);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      drive("add", 32'hE0821003, 1, 0, 0, 0, 4'b0000, E_ADD0);
      drive("cmp_imm", 32'hE3510005, 1, 0, 0, 0, 4'b0000,
            ev(1, 4'b0100, 6'b000101, 4'd1, 4'd5, 4'd0, 12'h005,
               24'h510005, 4'b0000, 0));
      drive("ldr", 32'hE5912004, 1, 0, 0, 0, 4'b0000,
            ev(1, 4'b0010, 6'b101001, 4'd1, 4'd4, 4'd2, 12'h004,
               24'h912004, 4'b0000, 0));
      drive("addeq_fail", 32'h00821003, 1, 0, 0, 0, 4'b0000,
            bub(4'b0000, 0));
      drive("addeq_fwd", 32'h00821003, 1, 0, 0, 1, 4'b0100, E_ADD4);
      drive("branch", 32'hEA000002, 1, 0, 0, 0, 4'b0000,
            ev(1, 4'b0000, 6'b000010, 4'd0, 4'd2, 4'd0, 12'h002,
               24'h000002, 4'b0100, 0));
      drive("flush_stall", 32'hE0821003, 1, 1, 1, 0, 4'b0000,
            bub(4'b0100, 0));
      drive("add2", 32'hE0821003, 1, 0, 0, 0, 4'b0000, E_ADD4);
      drive("stall1", 32'hE3510005, 1, 1, 0, 0, 4'b0000, E_ADD4);
      drive("stall2_fwe", 32'hE5912004, 1, 1, 0, 1, 4'b1001, E_ADD9);
      drive("stall3", 32'hEC000000, 1, 1, 0, 0, 4'b0000, E_ADD9);
      drive("addge", 32'hA0821003, 1, 0, 0, 0, 4'b0000, E_ADD9);
      drive("addlt", 32'hB0821003, 1, 0, 0, 0, 4'b0000,
            bub(4'b1001, 0));
      drive("cond_nv", 32'hF0821003, 1, 0, 0, 0, 4'b0000,
            bub(4'b1001, 0));
      drive("mode11", 32'hEC000000, 1, 0, 0, 0, 4'b0000,
            bub(4'b1001, 1));
      drive("opc0011", 32'hE0621003, 1, 0, 0, 0, 4'b0000,
            bub(4'b1001, 1));
      drive("ill_condfail", 32'h0C000000, 1, 0, 0, 0, 4'b0000,
            bub(4'b1001, 1));
      drive("ill_stall", 32'hE0821003, 1, 1, 0, 0, 4'b0000,
            bub(4'b1001, 1));
      drive("ill_flush", 32'hE0821003, 1, 0, 1, 0, 4'b0000,
            bub(4'b1001, 0));
      drive("mvns", 32'hE1F01002, 1, 0, 0, 0, 4'b0000,
            ev(1, 4'b1001, 6'b001100, 4'd0, 4'd2, 4'd1, 12'h002,
               24'hF01002, 4'b1001, 0));
      drive("str", 32'hE5812004, 1, 0, 0, 0, 4'b0000,
            ev(1, 4'b0010, 6'b010001, 4'd1, 4'd4, 4'd2, 12'h004,
               24'h812004, 4'b1001, 0));
      drive("tst_imm", 32'hE3110001, 1, 0, 0, 0, 4'b0000,
            ev(1, 4'b0110, 6'b000101, 4'd1, 4'd1, 4'd0, 12'h001,
               24'h110001, 4'b1001, 0));
      drive("not_valid", 32'hE0821003, 0, 0, 0, 0, 4'b0000,
            bub(4'b1001, 0));
      drive("addne_fwd", 32'h10821003, 1, 0, 0, 1, 4'b0100,
            bub(4'b0100, 0));
      drive("add3", 32'hE0821003, 1, 0, 0, 0, 4'b0000, E_ADD4);
      drain();

      // Asynchronous reset between edges with a live instruction in ID/EX.
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (act !== 64'd0) begin
         fails++;
         $display("FAIL async_reset: got %h expected %h", act, 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      begin
         exp_t x;
         x.v    = E_ADD0;
         x.name = "post_reset";
         exp_q.push_back(x);
      end
      drive("post_reset2", 32'hE0821003, 0, 0, 0, 0, 4'b0000,
            bub(4'b0000, 0));
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/id_exe_issue.md
# id_exe_issue

Instruction-decode issue stage that produces the `EXE_CMD` control word and operand fields consumed by the EXE-stage ALU. It also owns the architectural NZCV status register, which is written from the ALU flag outputs. It evaluates the ARM condition field against those flags and registers the decoded control into the ID/EX pipeline register, with stall and flush handling. It sits between instruction fetch and the EXE stage.

## Interface
- No parameters. Widths are fixed: 32-bit instruction, 4-bit `EXE_CMD`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: `instr` holds a fetched instruction.
- `instr` in 32: ARM instruction word.
- `stall` in 1: hold the ID/EX register contents.
- `flush` in 1: load a bubble into the ID/EX register.
- `flag_we` in 1: the EX instruction has S=1; write the NZCV register.
- `alu_n`, `alu_z`, `alu_c`, `alu_v` in 1 each: flags from the ALU.
- `ex_valid` out 1: the ID/EX register holds a live instruction.
- `ex_cmd` out 4: `EXE_CMD` to the ALU.
- `ex_mem_r`, `ex_mem_w`, `ex_wb_en`, `ex_s`, `ex_b`, `ex_imm` out 1 each: control bits.
- `ex_rn`, `ex_rm`, `ex_rd` out 4 each: register indices.
- `ex_shift_op` out 12: `instr[11:0]`.
- `ex_imm24` out 24: `instr[23:0]`.
- `status` out 4: registered {N,Z,C,V}.
- `illegal` out 1: registered; the last loaded instruction was undecodable.

## Operation
- Mode is taken from `instr[27:26]`: 00 = data-processing, 01 = memory, 10 = branch, 11 = illegal.
- Data-processing opcodes (`instr[24:21]`) map to `ex_cmd` as follows:
  - AND 0000 → 0110
  - EOR 0001 → 1000
  - SUB 0010 → 0100
  - ADD 0100 → 0010
  - ADC 0101 → 0011
  - SBC 0110 → 0101
  - TST 1000 → 0110
  - CMP 1010 → 0100
  - ORR 1100 → 0111
  - MOV 1101 → 0001
  - MVN 1111 → 1001
  - Any other opcode is illegal.
- Data-processing control bits:
  - `wb_en` = 1, except TST/CMP where it is 0.
  - `s` = `instr[20]`, forced to 1 for TST/CMP.
  - `imm` = `instr[25]`.
- Memory instructions:
  - `ex_cmd` = 0010 (address add) and `imm` = `~instr[25]`.
  - L = `instr[20]`. L=1 is LDR: `mem_r` = 1, `wb_en` = 1. L=0 is STR: `mem_w` = 1.
  - `s` = 0.
- Branch: `b` = 1, `ex_cmd` = 0000, all other control bits 0.
- Register fields: `rn` = `instr[19:16]`, `rd` = `instr[15:12]`, `rm` = `instr[3:0]`. STR reads Rd as data; `rd` is still driven from `instr[15:12]`.
- Effective flags: F = {`alu_n`,`alu_z`,`alu_c`,`alu_v`} when `flag_we`=1, otherwise `status`. This forwards the result of an S-instruction currently in EX.
- Condition `instr[31:28]` is evaluated against F:
  - EQ Z, NE ~Z
  - CS C, CC ~C
  - MI N, PL ~N
  - VS V, VC ~V
  - HI C&~Z, LS ~C|Z
  - GE N==V, LT N!=V
  - GT ~Z&(N==V), LE Z|(N!=V)
  - AL 1, 1111 0
- Bubble: `ex_valid` = 0, all control outputs 0 (`ex_cmd` 0000, `mem_r`/`mem_w`/`wb_en`/`s`/`b`/`imm` 0); register and immediate fields don't-care but driven 0.
- ID/EX load priority, evaluated each rising edge:
  - flush → bubble, `illegal` = 0.
  - else stall → hold everything.
  - else `in_valid` & cond pass & legal → decoded instruction, `ex_valid` = 1.
  - else `in_valid` & illegal (regardless of cond) → bubble, `illegal` = 1.
  - else → bubble, `illegal` = 0.
- Status register: on a rising edge with `flag_we`=1, `status` ← {`alu_n`,`alu_z`,`alu_c`,`alu_v`}. This write is independent of `stall` and `flush`; it belongs to the instruction already in EX.

## Timing
- Reset value of every output is 0: `ex_*`, `status` = 0000, `illegal` = 0. Reset is immediate on `rst_n` falling and independent of `clk`.
- Latency: an instruction presented at edge k appears on `ex_*` after edge k. One cycle, fully pipelined, one instruction per cycle.
- `stall` held for n cycles holds the outputs for n cycles. `instr` must be held by the upstream stage.
- `flush` and `stall` asserted together: flush wins.
- `flag_we` in the same cycle as a conditional instruction: the condition uses the forwarded ALU flags, not the stale `status`.
- Reset deasserted mid-stream: the first edge after release loads normally; no state survives reset.
- Decode and condition evaluation are combinational from `instr`, `status` and `alu_*`; all outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then `instr`=0xE0821003 (ADD r1,r2,r3) → next cycle: `ex_valid`=1, `ex_cmd`=0010, `wb_en`=1, `s`=0, `rn`=2, `rd`=1, `rm`=3, `imm`=0.
- 0xE3510005 (CMP r1,#5) → `ex_cmd`=0100, `wb_en`=0, `s`=1, `imm`=1, `ex_shift_op`=0x005. Then 0xE5912004 (LDR) → `ex_cmd`=0010, `mem_r`=1, `wb_en`=1, `imm`=1.
- `status`=0000 and `instr`=0x00821003 (ADDEQ) with `flag_we`=0 → bubble. Repeat with `flag_we`=1, `alu_z`=1 → issued. On the same edge `status` becomes 0100.
- 0xEA000002 (B) → `ex_b`=1, `ex_imm24`=0x000002, `ex_cmd`=0000. Next cycle assert `flush` and `stall` together → bubble.
- Hold `stall` for 3 cycles while `instr` changes → outputs unchanged. A concurrent `flag_we` still updates `status`.
- 0xEC000000 (mode 11) → bubble, `illegal`=1. Opcode 0011 (0xE0621003) → `illegal`=1. Assert `rst_n`=0 mid-cycle → all outputs 0 immediately.
